// File: rtl/router_sw_alloc.sv
// Switch allocator: round-robin output arbitration with credit flow control.
// Define ROUTER_SA_PKT_LOCK_EN to hold an output for a whole packet.
module router_sw_alloc #(
    parameter int NUM_PORTS = 5,
    parameter int CREDITS   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   req_ip,
    input  logic [3*NUM_PORTS-1:0] dest_ip,
    input  logic [NUM_PORTS-1:0]   tail_ip,
    input  logic [NUM_PORTS-1:0]   credit_in_op,
    output logic [NUM_PORTS-1:0]   gnt_ip,
    output logic [3*NUM_PORTS-1:0] sel_op,
    output logic [NUM_PORTS-1:0]   vld_op,
    output logic                   error
);

    typedef logic [2:0] port_t;
    typedef logic [3:0] cnt_t;

    port_t r_ptr [NUM_PORTS];
    cnt_t  r_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0] w_ok;
    logic [NUM_PORTS-1:0] w_bad;
    logic [NUM_PORTS-1:0] w_og;
    logic [NUM_PORTS-1:0] w_ovf;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_req;
    port_t w_gi  [NUM_PORTS];
    port_t w_nxt [NUM_PORTS];
    logic [3:0] w_idx;

`ifdef ROUTER_SA_PKT_LOCK_EN
    logic [NUM_PORTS-1:0] r_lock;
    port_t r_lock_in [NUM_PORTS];
`else
    logic w_unused_tail;
    assign w_unused_tail = ^tail_ip;
`endif

    always_comb begin
        w_ok  = '0;
        w_bad = '0;
        w_req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_ok[i]  = req_ip[i] &&
                       (dest_ip[3*i +: 3] < 3'(NUM_PORTS));
            w_bad[i] = req_ip[i] && !w_ok[i];
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_req[o][i] = !reset && w_ok[i] &&
                              (dest_ip[3*i +: 3] == 3'(o)) &&
                              (r_cnt[o] != '0);
`ifdef ROUTER_SA_PKT_LOCK_EN
                if (r_lock[o] && (r_lock_in[o] != 3'(i)))
                    w_req[o][i] = 1'b0;
`endif
            end
        end
    end

    // Search ptr, ptr+1, ... wrapping at NUM_PORTS; first hit wins.
    always_comb begin
        w_og  = '0;
        w_ovf = '0;
        w_idx = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_gi[o] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                w_idx = {1'b0, r_ptr[o]} + 4'(k);
                if (w_idx >= 4'(NUM_PORTS))
                    w_idx = w_idx - 4'(NUM_PORTS);
                if (!w_og[o] && w_req[o][w_idx[2:0]]) begin
                    w_og[o] = 1'b1;
                    w_gi[o] = w_idx[2:0];
                end
            end
            w_nxt[o] = (w_gi[o] == 3'(NUM_PORTS - 1)) ?
                       '0 : w_gi[o] + 3'd1;
            w_ovf[o] = credit_in_op[o] && !w_og[o] &&
                       (r_cnt[o] == 4'(CREDITS));
        end
    end

    always_comb begin
        gnt_ip = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_og[o])
                gnt_ip[w_gi[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_op <= '0;
            sel_op <= '0;
            error  <= 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_cnt[o] <= 4'(CREDITS);
                r_ptr[o] <= '0;
`ifdef ROUTER_SA_PKT_LOCK_EN
                r_lock[o]    <= 1'b0;
                r_lock_in[o] <= '0;
`endif
            end
        end else begin
            vld_op <= w_og;
            if (|w_bad || |w_ovf)
                error <= 1'b1;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_og[o])
                    sel_op[3*o +: 3] <= w_gi[o];
                if (w_og[o] && !credit_in_op[o])
                    r_cnt[o] <= r_cnt[o] - 4'd1;
                else if (!w_og[o] && credit_in_op[o] &&
                         (r_cnt[o] != 4'(CREDITS)))
                    r_cnt[o] <= r_cnt[o] + 4'd1;
`ifdef ROUTER_SA_PKT_LOCK_EN
                // Pointer advances only once the packet is done.
                if (w_og[o]) begin
                    if (tail_ip[w_gi[o]]) begin
                        r_lock[o] <= 1'b0;
                        r_ptr[o]  <= w_nxt[o];
                    end else begin
                        r_lock[o]    <= 1'b1;
                        r_lock_in[o] <= w_gi[o];
                    end
                end
`else
                if (w_og[o])
                    r_ptr[o] <= w_nxt[o];
`endif
            end
        end
    end

endmodule

// File: tb/tb_router_sw_alloc.sv
// Directed bench for router_sw_alloc with hand-computed expectations.
// Lock-mode expectations follow ROUTER_SA_PKT_LOCK_EN.
module tb_router_sw_alloc;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  req_ip;
    logic [14:0] dest_ip;
    logic [4:0]  tail_ip;
    logic [4:0]  credit_in_op;
    logic [4:0]  gnt_ip;
    logic [14:0] sel_op;
    logic [4:0]  vld_op;
    logic        error;

    int n_tot = 0;
    int n_bad = 0;
    int seq [4];
    int exp_i;

    always #5 clk = ~clk;

    router_sw_alloc #(.NUM_PORTS(5), .CREDITS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_ip       (req_ip),
        .dest_ip      (dest_ip),
        .tail_ip      (tail_ip),
        .credit_in_op (credit_in_op),
        .gnt_ip       (gnt_ip),
        .sel_op       (sel_op),
        .vld_op       (vld_op),
        .error        (error)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        req_ip       = '0;
        dest_ip      = '0;
        tail_ip      = '0;
        credit_in_op = '0;
        tick;
        tick;
        req_ip = 5'b00001;
        #1 chk("rst_gnt", 32'(gnt_ip), 0);
        chk("rst_vld", 32'(vld_op), 0);
        chk("rst_sel", 32'(sel_op), 0);
        chk("rst_err", 32'(error), 0);
        reset  = 1'b0;
        req_ip = '0;
        tick;

        // Three inputs contend for output 3 with credits returned.
        req_ip       = 5'b00111;
        dest_ip      = {3'd0, 3'd0, 3'd3, 3'd3, 3'd3};
        credit_in_op = 5'b01000;
        for (int k = 0; k < 6; k++) begin
            exp_i = k % 3;
            #1 chk("rr_gnt", 32'(gnt_ip), 32'(1 << exp_i));
            tick;
            chk("rr_vld", 32'(vld_op), 32'h08);
            chk("rr_sel", 32'(sel_op[11:9]), 32'(exp_i));
        end
        req_ip       = '0;
        credit_in_op = '0;
        tick;
        chk("idle_vld", 32'(vld_op), 0);
        chk("hold_sel", 32'(sel_op[11:9]), 2);
        chk("rr_err", 32'(error), 0);

        // Input 4 to output 0 drains all four credits.
        req_ip  = 5'b10000;
        dest_ip = '0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("cr_gnt", 32'(gnt_ip), 32'h10);
            tick;
            chk("cr_sel", 32'(sel_op[2:0]), 4);
        end
        for (int k = 0; k < 3; k++) begin
            #1 chk("cr_stall", 32'(gnt_ip), 0);
            tick;
            chk("cr_novld", 32'(vld_op[0]), 0);
        end
        credit_in_op = 5'b00001;
        #1 chk("cr_nocomb", 32'(gnt_ip), 0);
        tick;
        credit_in_op = '0;
        #1 chk("cr_one", 32'(gnt_ip), 32'h10);
        tick;
        #1 chk("cr_empty", 32'(gnt_ip), 0);
        req_ip       = '0;
        credit_in_op = 5'b00001;
        for (int k = 0; k < 4; k++) tick;
        credit_in_op = '0;
        chk("cr_err", 32'(error), 0);

        // Grant and credit together on output 2 at cnt=1.
        req_ip  = 5'b00010;
        dest_ip = {3'd0, 3'd0, 3'd0, 3'd2, 3'd0};
        for (int k = 0; k < 3; k++) begin
            #1 chk("gc_drain", 32'(gnt_ip), 32'h02);
            tick;
        end
        credit_in_op = 5'b00100;
        #1 chk("gc_both", 32'(gnt_ip), 32'h02);
        tick;
        credit_in_op = '0;
        #1 chk("gc_again", 32'(gnt_ip), 32'h02);
        tick;
        #1 chk("gc_zero", 32'(gnt_ip), 0);
        req_ip       = '0;
        credit_in_op = 5'b00100;
        for (int k = 0; k < 4; k++) tick;
        credit_in_op = '0;
        chk("gc_err", 32'(error), 0);

        // Credit return into a full counter.
        credit_in_op = 5'b00010;
        #1 chk("ov_pre", 32'(error), 0);
        tick;
        credit_in_op = '0;
        chk("ov_err", 32'(error), 1);
        tick;
        tick;
        chk("ov_sticky", 32'(error), 1);

        // Reset in the middle of traffic.
        req_ip  = 5'b00001;
        dest_ip = '0;
        reset   = 1'b1;
        #1 chk("mid_gnt", 32'(gnt_ip), 0);
        tick;
        chk("mid_err", 32'(error), 0);
        chk("mid_vld", 32'(vld_op), 0);
        reset = 1'b0;
        #1 chk("mid_resume", 32'(gnt_ip), 32'h01);
        tick;
        chk("mid_vld1", 32'(vld_op), 32'h01);
        req_ip       = '0;
        credit_in_op = 5'b00001;
        tick;
        credit_in_op = '0;

        // Out-of-range destination on input 3.
        req_ip  = 5'b01001;
        dest_ip = {3'd0, 3'd6, 3'd0, 3'd0, 3'd1};
        #1 chk("bd_gnt", 32'(gnt_ip), 32'h01);
        chk("bd_pre", 32'(error), 0);
        tick;
        req_ip = '0;
        chk("bd_err", 32'(error), 1);
        chk("bd_vld", 32'(vld_op), 32'h02);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        chk("bd_clr", 32'(error), 0);

        // Inputs 0 and 2 to output 1, input 0 sends a 3-flit packet.
`ifdef ROUTER_SA_PKT_LOCK_EN
        seq = '{0, 0, 0, 2};
`else
        seq = '{0, 2, 0, 2};
`endif
        req_ip       = 5'b00101;
        dest_ip      = {3'd0, 3'd0, 3'd1, 3'd0, 3'd1};
        credit_in_op = 5'b00010;
        for (int k = 0; k < 4; k++) begin
            tail_ip = (k == 2) ? 5'b00001 : 5'b00000;
            #1 chk("pk_gnt", 32'(gnt_ip), 32'(1 << seq[k]));
            tick;
            chk("pk_sel", 32'(sel_op[5:3]), 32'(seq[k]));
        end
        req_ip       = '0;
        tail_ip      = '0;
        credit_in_op = '0;
        tick;
        chk("pk_err", 32'(error), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
